// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-ported register file.
package rf_pkg;

   // Bulk-clear sequencer states.
   typedef enum logic {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } rf_clr_state_e;

   // Number of registers addressed by an aw-bit address.
   function automatic int rf_nr(input int aw_v);
      return 1 << aw_v;
   endfunction

endpackage

// File: rtl/rf_mp_if.sv
// Bus bundle for rf_mp: read/write ports plus the bulk-clear handshake.
//
// Clear handshake: clr_req is a one-cycle request sampled at the rising
// edge while busy is low. It is ignored while busy is high. busy stays
// high for exactly one cycle per register while the clear sequence runs,
// and writes are dropped for that whole time. clr_done pulses high for
// one cycle right after the last register has been zeroed. A clr_req in
// that clr_done cycle is accepted and starts a new clear.
interface rf_mp_if #(
   parameter int bw  = 8,
   parameter int aw  = 4,
   parameter int nrp = 2,
   parameter int nwp = 1
);
   logic [nrp-1:0][aw-1:0] ra;
   logic [nrp-1:0][bw-1:0] rdata;
   logic [nwp-1:0][aw-1:0] wa;
   logic [nwp-1:0][bw-1:0] wdata;
   logic [nwp-1:0]         we;
   logic                   clr_req;
   logic                   busy;
   logic                   clr_done;

   modport master (
      output ra, wa, wdata, we, clr_req,
      input  rdata, busy, clr_done
   );

   modport slave (
      input  ra, wa, wdata, we, clr_req,
      output rdata, busy, clr_done
   );
endinterface

// File: rtl/rf_clr_seq.sv
// Bulk-clear sequencer: walks every register address once, one per cycle.
module rf_clr_seq
   import rf_pkg::*;
#(
   parameter int aw = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_done,
   output logic          clr_we,
   output logic [aw-1:0] clr_addr
);

   rf_clr_state_e state;
   logic [aw-1:0] cnt;

   // Clear FSM: accept a request when idle, then zero one address per edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= CLR_IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            CLR_IDLE: begin
               if (clr_req) begin
                  state <= CLR_RUN;
                  cnt   <= '0;
               end
            end
            CLR_RUN: begin
               // cnt wraps back to zero on the final step by itself.
               cnt <= cnt + 1'b1;
               if (cnt == {aw{1'b1}}) begin
                  state    <= CLR_IDLE;
                  clr_done <= 1'b1;
               end
            end
            default: state <= CLR_IDLE;
         endcase
      end
   end

   assign busy     = (state == CLR_RUN);
   assign clr_we   = busy;
   assign clr_addr = cnt;

endmodule

// File: rtl/rf_mp.sv
// Multi-ported register file with optional hardwired R0, write-to-read
// bypass and a sequenced bulk-clear engine.
module rf_mp
   import rf_pkg::*;
#(
   parameter int bw      = 8,
   parameter int aw      = 4,
   parameter int nrp     = 2,
   parameter int nwp     = 1,
   parameter bit zero_r0 = 1'b0,
   parameter bit bypass  = 1'b1
) (
   input  logic  clk,
   input  logic  rst,
   rf_mp_if.slave bus
);

   localparam int nr = rf_nr(aw);

   logic [bw-1:0]          regs [nr];
   logic                   busy;
   logic                   clr_done;
   logic                   clr_we;
   logic [aw-1:0]          clr_addr;
   logic [nrp-1:0][bw-1:0] rdata;

   rf_clr_seq #(.aw(aw)) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (bus.clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // Storage update: clear step while busy, otherwise write ports in index
   // order so the highest-indexed port wins an address collision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < nr; i++) begin
            regs[i] <= '0;
         end
      end else if (clr_we) begin
         regs[clr_addr] <= '0;
      end else begin
         for (int w = 0; w < nwp; w++) begin
            if (bus.we[w] && !(zero_r0 && (bus.wa[w] == '0))) begin
               regs[bus.wa[w]] <= bus.wdata[w];
            end
         end
      end
   end

   // Read mux: stored value, overridden by same-cycle write data when bypass
   // is enabled and idle; hardwired R0 and held reset force zero last.
   always_comb begin
      rdata = '0;
      for (int p = 0; p < nrp; p++) begin
         rdata[p] = regs[bus.ra[p]];
         if (bypass && !busy) begin
            for (int w = 0; w < nwp; w++) begin
               if (bus.we[w] && (bus.wa[w] == bus.ra[p])) begin
                  rdata[p] = bus.wdata[w];
               end
            end
         end
         if (zero_r0 && (bus.ra[p] == '0)) begin
            rdata[p] = '0;
         end
         if (!rst) begin
            rdata[p] = '0;
         end
      end
   end

   assign bus.rdata    = rdata;
   assign bus.busy     = busy;
   assign bus.clr_done = clr_done;

endmodule
